// File: rtl/piano_key_arbiter.sv
// Key arbiter for the piano: the most recently pressed key wins and play falls back to the lowest held key.
// A post-release tail, counted in iTick pulses, keeps the note valid while the buzzer decays.
module piano_key_arbiter #(
  parameter int NUM_KEYS   = 8,
  parameter int NOTE_W     = 3,
  parameter int TAIL_TICKS = 5
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                iTick,
  input  logic [NUM_KEYS-1:0] iKeys,
  output logic [NOTE_W-1:0]   oNote,
  output logic                oNoteValid,
  output logic                oCountEnable,
  output logic                oNoteChange
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  localparam logic [7:0] TAIL_LAST = 8'(TAIL_TICKS - 1);

  state_e                state_q, state_d;
  logic [NOTE_W-1:0]     note_q, note_d;
  logic                  note_valid_q, note_valid_d;
  logic                  count_en_q, count_en_d;
  logic                  note_change_q, note_change_d;
  logic [NUM_KEYS-1:0]   kprev_q, kprev_d;
  logic [7:0]            tail_cnt_q, tail_cnt_d;
  logic [NUM_KEYS-1:0]   rise_s;

  function automatic logic [NOTE_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [NOTE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = NOTE_W'(i);
      end
    end
    return idx;
  endfunction

  assign rise_s = iKeys & ~kprev_q;

  always_comb begin
    state_d       = state_q;
    note_d        = note_q;
    note_valid_d  = note_valid_q;
    count_en_d    = count_en_q;
    note_change_d = 1'b0;
    tail_cnt_d    = tail_cnt_q;
    kprev_d       = iKeys;

    case (state_q)
      ST_IDLE: begin
        if (rise_s != '0) begin
          state_d       = ST_PLAY;
          note_d        = lowest_idx(rise_s);
          note_change_d = 1'b1;
          note_valid_d  = 1'b1;
          count_en_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (rise_s != '0) begin
          note_d        = lowest_idx(rise_s);
          note_change_d = 1'b1;
        end else if (!iKeys[note_q] && (iKeys != '0)) begin
          note_d        = lowest_idx(iKeys);
          note_change_d = 1'b1;
        end else if (iKeys == '0) begin
          state_d    = ST_TAIL;
          tail_cnt_d = 8'd0;
          count_en_d = 1'b0;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_TAIL: begin
        // A new press beats tail expiry in the same cycle.
        if (rise_s != '0) begin
          state_d       = ST_PLAY;
          note_d        = lowest_idx(rise_s);
          note_change_d = 1'b1;
          count_en_d    = 1'b1;
        end else if (iTick) begin
          if (tail_cnt_q == TAIL_LAST) begin
            state_d      = ST_IDLE;
            note_valid_d = 1'b0;
          end else begin
            tail_cnt_d = tail_cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_TAIL;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        note_valid_d = 1'b0;
        count_en_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q       <= ST_IDLE;
      note_q        <= '0;
      note_valid_q  <= 1'b0;
      count_en_q    <= 1'b0;
      note_change_q <= 1'b0;
      kprev_q       <= '0;
      tail_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      note_q        <= note_d;
      note_valid_q  <= note_valid_d;
      count_en_q    <= count_en_d;
      note_change_q <= note_change_d;
      kprev_q       <= kprev_d;
      tail_cnt_q    <= tail_cnt_d;
    end
  end

  assign oNote        = note_q;
  assign oNoteValid   = note_valid_q;
  assign oCountEnable = count_en_q;
  assign oNoteChange  = note_change_q;

endmodule
